// File: rtl/serial_add_ctrl.sv
// Bit-serial add/subtract controller: time-multiplexes a single FullAdder cell
// over WIDTH clocks, LSB first, with a start/busy/done handshake.
module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_r;
    state_t           state_s;
    logic [WIDTH-1:0] a_sr_r;
    logic [WIDTH-1:0] b_sr_r;
    logic [WIDTH-1:0] res_sr_r;
    logic             carry_r;
    logic [CW-1:0]    cnt_r;
    logic             fa_cout_s;
    logic             fa_sum_s;
    logic             last_s;
    logic             busy_s;
    logic             done_s;

    FullAdder u_fa (
        .A    (a_sr_r[0]),
        .B    (b_sr_r[0]),
        .Cin  (carry_r),
        .Cout (fa_cout_s),
        .Sum  (fa_sum_s)
    );

    assign last_s = (state_r == RUN) && (cnt_r == LAST_CNT);

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_s = RUN;
                end else begin
                    state_s = IDLE;
                end
            end
            RUN: begin
                if (last_s) begin
                    state_s = DONE;
                end else begin
                    state_s = RUN;
                end
            end
            DONE:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // FSM output decode; busy drops on the final RUN edge so it never overlaps done
    always_comb begin
        busy_s = 1'b0;
        done_s = 1'b0;
        case (state_r)
            RUN: begin
                if (last_s) begin
                    done_s = 1'b1;
                end else begin
                    busy_s = 1'b1;
                end
            end
            default: begin
                busy_s = 1'b0;
                done_s = 1'b0;
            end
        endcase
    end

    // Handshake output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            busy <= busy_s;
            done <= done_s;
        end
    end

    // Operand capture, serial shifting and result/flag registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sr_r   <= '0;
            b_sr_r   <= '0;
            res_sr_r <= '0;
            carry_r  <= 1'b0;
            cnt_r    <= '0;
            sum      <= '0;
            cout     <= 1'b0;
            ovf      <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start) begin
                        a_sr_r  <= a;
                        b_sr_r  <= sub ? ~b : b;
                        carry_r <= sub ? 1'b1 : cin;
                        cnt_r   <= '0;
                    end else begin
                        cnt_r   <= cnt_r;
                    end
                end
                RUN: begin
                    res_sr_r <= {fa_sum_s, res_sr_r[WIDTH-1:1]};
                    a_sr_r   <= {1'b0, a_sr_r[WIDTH-1:1]};
                    b_sr_r   <= {1'b0, b_sr_r[WIDTH-1:1]};
                    carry_r  <= fa_cout_s;
                    cnt_r    <= cnt_r + CW'(1);
                    if (last_s) begin
                        sum  <= {fa_sum_s, res_sr_r[WIDTH-1:1]};
                        cout <= fa_cout_s;
                        // carry_r still holds the carry into the MSB here
                        ovf  <= carry_r ^ fa_cout_s;
                    end else begin
                        cout <= cout;
                    end
                end
                default: begin
                    cnt_r <= cnt_r;
                end
            endcase
        end
    end
endmodule

// One-bit full adder cell shared by the serial datapath.
module FullAdder (
    input  logic A,
    input  logic B,
    input  logic Cin,
    output logic Cout,
    output logic Sum
);
    assign Sum  = A ^ B ^ Cin;
    assign Cout = (A & B) | (Cin & (A ^ B));
endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed bench for serial_add_ctrl at WIDTH=8 and WIDTH=2.
module tb_serial_add_ctrl;
    logic       clk;
    logic       rst_n;
    logic       start8, sub8, cin8;
    logic [7:0] a8, b8;
    logic       busy8, done8, cout8, ovf8;
    logic [7:0] sum8;
    logic       start2, sub2, cin2;
    logic [1:0] a2, b2;
    logic       busy2, done2, cout2, ovf2;
    logic [1:0] sum2;
    int         errors;
    int         checks;

    serial_add_ctrl #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .sub(sub8), .a(a8), .b(b8),
        .cin(cin8), .busy(busy8), .done(done8), .sum(sum8), .cout(cout8), .ovf(ovf8)
    );

    serial_add_ctrl #(.WIDTH(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .sub(sub2), .a(a2), .b(b2),
        .cin(cin2), .busy(busy2), .done(done2), .sum(sum2), .cout(cout2), .ovf(ovf2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if ({busy8, done8, sum8, cout8, ovf8} !== 11'd0) begin
            errors++;
            $display("FAIL reset_outputs: got busy=%b done=%b sum=%h cout=%b ovf=%b, expected all 0",
                     busy8, done8, sum8, cout8, ovf8);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // One WIDTH=8 operation with cycle-exact busy/done checks.
    task automatic run8(input logic s, input logic [7:0] av, input logic [7:0] bv,
                        input logic c, input logic [7:0] es, input logic ec,
                        input logic eo, input string name);
        @(negedge clk);
        start8 = 1'b1; sub8 = s; a8 = av; b8 = bv; cin8 = c;
        @(posedge clk);
        #1;
        checks++;
        if (busy8 !== 1'b0 || done8 !== 1'b0) begin
            errors++;
            $display("FAIL %s_accept_cycle: got busy=%b done=%b, expected 0 0", name, busy8, done8);
        end
        @(negedge clk);
        start8 = 1'b0; a8 = ~av; b8 = ~bv; cin8 = ~c; sub8 = ~s;
        for (int cyc = 1; cyc <= 8; cyc++) begin
            @(posedge clk);
            #1;
            checks++;
            if (busy8 !== (cyc <= 7) || done8 !== (cyc == 8)) begin
                errors++;
                $display("FAIL %s_timing_c%0d: got busy=%b done=%b, expected busy=%b done=%b",
                         name, cyc, busy8, done8, cyc <= 7, cyc == 8);
            end
        end
        checks++;
        if (sum8 !== es || cout8 !== ec || ovf8 !== eo) begin
            errors++;
            $display("FAIL %s_result: got sum=%h cout=%b ovf=%b, expected sum=%h cout=%b ovf=%b",
                     name, sum8, cout8, ovf8, es, ec, eo);
        end
        @(posedge clk);
        #1;
        checks++;
        if (done8 !== 1'b0) begin
            errors++;
            $display("FAIL %s_done_width: got done=%b, expected 0", name, done8);
        end
    endtask

    task automatic test_add();
        run8(1'b0, 8'h5A, 8'h33, 1'b0, 8'h8D, 1'b0, 1'b1, "add_5a_33");
        run8(1'b0, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, "add_ff_01");
        run8(1'b0, 8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0, "add_ff_00_cin");
    endtask

    task automatic test_sub();
        run8(1'b1, 8'h10, 8'h20, 1'b0, 8'hF0, 1'b0, 1'b0, "sub_10_20");
        run8(1'b1, 8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1, "sub_80_01");
    endtask

    task automatic run2(input logic s, input logic [1:0] av, input logic [1:0] bv,
                        input logic c);
        int  sa, sb, r, ures;
        logic ok;
        logic [1:0] es;
        logic ec, eo;
        sa = (av >= 2'd2) ? int'(av) - 4 : int'(av);
        sb = (bv >= 2'd2) ? int'(bv) - 4 : int'(bv);
        if (s) begin
            r    = sa - sb;
            ures = int'(av) - int'(bv);
            es   = 2'(ures);
            ec   = (av >= bv);
        end else begin
            r    = sa + sb + int'(c);
            ures = int'(av) + int'(bv) + int'(c);
            es   = 2'(ures);
            ec   = (ures >= 4);
        end
        eo = (r > 1) || (r < -2);
        @(negedge clk);
        start2 = 1'b1; sub2 = s; a2 = av; b2 = bv; cin2 = c;
        @(posedge clk);
        @(negedge clk);
        start2 = 1'b0; a2 = ~av; b2 = ~bv;
        ok = 1'b0;
        for (int n = 0; n < 16 && !ok; n++) begin
            @(posedge clk);
            #1;
            ok = done2;
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL w2_timeout: sub=%b a=%0d b=%0d cin=%b, no done within 16 cycles", s, av, bv, c);
        end else if (sum2 !== es || cout2 !== ec || ovf2 !== eo) begin
            errors++;
            $display("FAIL w2_result: sub=%b a=%0d b=%0d cin=%b got sum=%0d cout=%b ovf=%b, expected sum=%0d cout=%b ovf=%b",
                     s, av, bv, c, sum2, cout2, ovf2, es, ec, eo);
        end
        @(posedge clk);
    endtask

    task automatic test_width2();
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
                for (int k = 0; k < 2; k++)
                    run2(1'b0, 2'(i), 2'(j), 1'(k));
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
                run2(1'b1, 2'(i), 2'(j), 1'(i));
    endtask

    // start held high while operands change every cycle
    task automatic test_back_to_back();
        logic [7:0] ea, eb;
        @(negedge clk);
        start8 = 1'b1; sub8 = 1'b0; cin8 = 1'b0;
        a8 = 8'(3); b8 = 8'(5);
        for (int i = 0; i < 30; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if (done8 !== ((i % 10) == 8)) begin
                errors++;
                $display("FAIL b2b_done_i%0d: got done=%b, expected %b", i, done8, (i % 10) == 8);
            end
            if ((i % 10) == 8) begin
                ea = 8'((i - 8) * 7 + 3);
                eb = 8'((i - 8) * 13 + 5);
                checks++;
                if (sum8 !== 8'(ea + eb)) begin
                    errors++;
                    $display("FAIL b2b_sum_i%0d: got %h, expected %h", i, sum8, 8'(ea + eb));
                end
            end
            @(negedge clk);
            a8 = 8'((i + 1) * 7 + 3);
            b8 = 8'((i + 1) * 13 + 5);
        end
        start8 = 1'b0;
    endtask

    task automatic test_reset_mid_run();
        logic seen;
        @(negedge clk);
        start8 = 1'b1; sub8 = 1'b0; a8 = 8'h5A; b8 = 8'h33; cin8 = 1'b0;
        @(posedge clk);
        @(negedge clk);
        start8 = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({busy8, done8, sum8, cout8, ovf8} !== 11'd0) begin
            errors++;
            $display("FAIL midrun_reset: got busy=%b done=%b sum=%h cout=%b ovf=%b, expected all 0",
                     busy8, done8, sum8, cout8, ovf8);
        end
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int n = 0; n < 12; n++) begin
            @(posedge clk);
            #1;
            seen = seen | done8 | busy8;
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("FAIL midrun_no_done: got activity=%b after reset, expected 0", seen);
        end
        run8(1'b0, 8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0, "post_reset_add");
    endtask

    initial begin
        errors = 0; checks = 0;
        start8 = 1'b0; sub8 = 1'b0; cin8 = 1'b0; a8 = 8'h00; b8 = 8'h00;
        start2 = 1'b0; sub2 = 1'b0; cin2 = 1'b0; a2 = 2'd0; b2 = 2'd0;
        test_reset();
        test_add();
        test_sub();
        test_width2();
        test_back_to_back();
        test_reset_mid_run();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/serial_add_ctrl.md
Name: serial_add_ctrl

Overview:
- Bit-serial adder/subtractor controller. It time-multiplexes one instance of the team's FullAdder cell (port order A, B, Cin, Cout, Sum) to add or subtract two WIDTH-bit operands, LSB first, one bit per clock.
- It sits between a requester and the FullAdder datapath, providing a start/busy/done handshake and the result/flag registers.

Parameters:
- WIDTH, 8: operand and result width in bits; legal range 2..32.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request pulse/level; sampled only in IDLE.
- sub  input  1  0 = add (a + b + cin); 1 = subtract (a - b), cin ignored.
- a  input  WIDTH  operand A, captured when start is accepted.
- b  input  WIDTH  operand B, captured when start is accepted.
- cin  input  1  carry-in for add, captured with the operands.
- busy  output  1  high while a bit-serial operation is in progress.
- done  output  1  one-cycle pulse: result valid.
- sum  output  WIDTH  result register, held until the next accepted start.
- cout  output  1  final carry-out (for sub: 1 = no borrow).
- ovf  output  1  signed overflow = carry into MSB XOR carry out of MSB.

Behaviour:
- Reset (rst_n low, asynchronous, any state): state=IDLE; busy=0, done=0, sum=0, cout=0, ovf=0; shift registers, carry register and bit counter cleared. An operation in flight is abandoned. No done pulse follows a reset.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - start=1 at a rising edge accepts the request.
  - Latch a into the A shift register.
  - Latch b (or ~b when sub=1) into the B shift register.
  - Set the carry register to cin (or 1 when sub=1).
  - Clear the bit counter. Go to RUN.
  - sum/cout/ovf keep their previous values until the final RUN edge.
- RUN (busy=1):
  - The FullAdder is fed A=A_sr[0], B=B_sr[0], Cin=carry_reg.
  - Each edge: shift Sum into the result shift register from the MSB side, moving right; shift A_sr/B_sr right; carry_reg<=Cout; counter++.
  - On the edge where counter==WIDTH-1, in the same edge:
    - Write the assembled WIDTH-bit result into sum.
    - cout <= FullAdder Cout.
    - ovf <= carry_reg (the carry into the MSB) XOR Cout.
    - Go to DONE.
  - start is ignored while in RUN.
- DONE: done=1, busy=0 for exactly one cycle; next edge goes to IDLE unconditionally. start is ignored in DONE, so the requester must hold or re-assert start into IDLE.
- Latency: start is sampled at edge k. busy is high after edges k+1 .. k+WIDTH−1. done is high during the cycle after edge k+WIDTH. Back-to-back throughput is one operation per WIDTH+2 cycles.
- Width rules:
  - Counter width is $clog2(WIDTH).
  - All arithmetic is modulo 2^WIDTH. No sign extension.
  - ovf is meaningful for two's-complement operands; cout for unsigned.
- Operand inputs a/b/cin/sub may change freely after acceptance without affecting the running operation.
- Outputs are registered; no combinational path from the inputs to any output.

Test Plan:
- WIDTH=8, reset, then add a=0x5A, b=0x33, cin=0 -> done exactly 8 cycles after the accepting edge (busy high for the 7 cycles before it); sum=0x8D, cout=0, ovf=1.
- Add a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1, ovf=0. Then a=0xFF, b=0x00, cin=1 -> sum=0x00, cout=1, ovf=0.
- Subtract (sub=1) a=0x10, b=0x20 -> sum=0xF0, cout=0, ovf=0. Then a=0x80, b=0x01 -> sum=0x7F, cout=1, ovf=1.
- Exhaustive 1-bit-cell check via WIDTH=2:
  - Sweep all a, b, cin for add; check {cout,sum} == a+b+cin.
  - Sweep all a, b for sub; check sum == (a−b) mod 4.
  - Check ovf against a signed reference.
- Hold start=1 continuously with changing a/b -> start is accepted only in IDLE; successive done pulses are WIDTH+2 cycles apart; results match the operands captured at each accepting edge.
- Drive rst_n low mid-RUN, at counter=3 with 0x5A+0x33 -> all outputs 0 immediately (asynchronous, no clock edge needed); no done pulse; the next start 0x01+0x01 gives sum=0x02.
